ldpc_3gpp_dec_source_fix: RTL and testbench

Fixed-mode 3GPP LDPC decoder input stage, the receiving end of the encoder sink stream. It accepts a codeword as a sop/val/eop stream of LLR words and writes it into the decoder ping-pong input buffer. When punctured mode is on, it also writes zero LLRs for the 2·Zc punctured systematic columns. It sits between the demapper/rate-dematcher and the `codec_buffer` feeding the fixed decoder engine.

---
 rtl/ldpc_3gpp_dec_source_fix_pkg.sv | 44 ++++
 rtl/ldpc_3gpp_dec_source_fix.sv | 130 +++++++++++++
 tb/tb_ldpc_3gpp_dec_source_fix.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_3gpp_dec_source_fix_pkg.sv
// Types and sizing helpers for the fixed-mode LDPC decoder input path,
// shared with the fixed decoder engine.
package ldpc_3gpp_dec_source_fix_pkg;

    typedef enum logic [1:0] {StIdle, StData, StZfill, StDone} frame_state_t;

    // 3GPP lifting sizes: Zc = a * 2^j, with a picked by the lifting set index.
    function automatic int unsigned zc_tab(int unsigned ls, int unsigned idx);
        int unsigned a;
        case (ls)
            0:       a = 2;
            1:       a = 3;
            2:       a = 5;
            3:       a = 7;
            4:       a = 9;
            5:       a = 11;
            6:       a = 13;
            7:       a = 15;
            default: a = 2;
        endcase
        return a << idx;
    endfunction

    function automatic int unsigned clogb2(int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned num_words(int unsigned gr, int unsigned code,
                                              int unsigned zc_w);
        int unsigned c;
        c = (code < 4) ? 4 : code;
        return (((gr != 0) ? 10 : 22) + c) * zc_w;
    endfunction

    function automatic int unsigned punct_words(int unsigned do_punct, int unsigned zc_w);
        return (do_punct != 0) ? 2 * zc_w : 0;
    endfunction

endpackage

// File: rtl/ldpc_3gpp_dec_source_fix.sv
// Decoder input stage: writes a sop/val/eop LLR stream into the ping-pong input
// buffer and, in punctured mode, zero-fills the 2*Zc punctured columns.
module ldpc_3gpp_dec_source_fix
    import ldpc_3gpp_dec_source_fix_pkg::*;
#(
    parameter int pLLR_W    = 4,
    parameter int pDAT_W    = 8,
    parameter int pTAG_W    = 4,
    parameter int pIDX_GR   = 0,
    parameter int pIDX_LS   = 0,
    parameter int pIDX_ZC   = 3,
    parameter int pCODE     = 4,
    parameter int pDO_PUNCT = 0,
    parameter int pADDR_W   = 8
) (
    input  logic                       iclk,
    input  logic                       ireset,
    input  logic                       iclkena,
    input  logic                       isop,
    input  logic                       ival,
    input  logic                       ieop,
    input  logic [pDAT_W*pLLR_W-1:0]   idat,
    input  logic [pTAG_W-1:0]          itag,
    input  logic                       ifulla,
    input  logic                       iemptya,
    output logic                       ordy,
    output logic                       obusy,
    output logic                       owrite,
    output logic                       owfull,
    output logic [pADDR_W-1:0]         owaddr,
    output logic [pDAT_W*pLLR_W-1:0]   owdat,
    output logic [pTAG_W-1:0]          owtag,
    output logic                       oerr
);

    localparam int cZC    = int'(zc_tab(pIDX_LS, pIDX_ZC)) / pDAT_W;
    localparam int cNUM   = int'(num_words(pIDX_GR, pCODE, cZC));
    localparam int cP     = int'(punct_words(pDO_PUNCT, cZC));
    localparam int cCNT_W = pADDR_W + 1;
    localparam int cDW    = pDAT_W * pLLR_W;

    localparam logic [cCNT_W-1:0] cNUM_C  = cCNT_W'(cNUM);
    localparam logic [cCNT_W-1:0] cP_C    = cCNT_W'(cP);
    localparam logic [cCNT_W-1:0] cP_LAST = cCNT_W'((cP > 0) ? cP - 1 : 0);

    frame_state_t              state_q, state_d;
    logic [cCNT_W-1:0]         addr_q, addr_d;
    logic [pTAG_W-1:0]         tag_q, tag_d;
    logic                      err_q, err_d;
    logic                      accept;
    logic [cCNT_W-1:0]         wptr, wnext;
    logic                      wr_d;
    logic [pADDR_W-1:0]        waddr_d;
    logic [cDW-1:0]            wdat_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        err_d   = err_q;
        accept  = 1'b0;
        wptr    = addr_q;
        wnext   = addr_q;
        wr_d    = 1'b0;
        waddr_d = '0;
        wdat_d  = '0;

        unique case (state_q)
            StIdle:  accept = ival & isop;
            StData:  accept = ival;
            StZfill: begin
                wr_d    = 1'b1;
                waddr_d = addr_q[pADDR_W-1:0];
                addr_d  = addr_q + 1'b1;
                if (addr_q == cP_LAST) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            // A sop anywhere restarts the frame at the first unpunctured column.
            wptr = isop ? cP_C : addr_q;
            if (isop) tag_d = itag;
            wr_d    = (wptr < cNUM_C);
            waddr_d = wr_d ? wptr[pADDR_W-1:0] : '0;
            wdat_d  = wr_d ? idat : '0;
            // Saturate so an overlong frame cannot wrap back to a "correct" count.
            wnext   = (&wptr) ? wptr : wptr + 1'b1;
            addr_d  = wnext;
            state_d = StData;
            if (ieop) begin
                err_d   = (wnext != cNUM_C);
                addr_d  = '0;
                state_d = (cP > 0) ? StZfill : StDone;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
            ordy    <= 1'b0;
            owrite  <= 1'b0;
            owaddr  <= '0;
            owdat   <= '0;
            owfull  <= 1'b0;
            owtag   <= '0;
            oerr    <= 1'b0;
        end else if (iclkena) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
            ordy    <= (state_d == StIdle) & ~ifulla;
            owrite  <= wr_d;
            owaddr  <= waddr_d;
            owdat   <= wdat_d;
            owfull  <= (state_q == StDone);
            owtag   <= (state_q == StDone) ? tag_q : '0;
            oerr    <= (state_q == StDone) & err_q;
        end
    end

    assign obusy = (state_q != StIdle) | ~iemptya;

endmodule

// File: tb/tb_ldpc_3gpp_dec_source_fix.sv
// Bench for the decoder input stage: one unpunctured and one punctured instance
// share the stream; writes and bank-complete strobes are checked against a model.
module tb_ldpc_3gpp_dec_source_fix;

    localparam int NUM = 52;   // (22 + 4) columns * 16/8 words
    localparam int P1  = 4;    // 2 * Zc words for the punctured instance

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] dat;
    } wr_t;

    typedef struct {
        int         cyc;
        logic [3:0] tag;
        logic       err;
    } full_t;

    typedef struct {
        int n;
        int rs;
        int e0;
        int e1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, clkena, isop, ival, ieop, ifulla, iemptya;
    logic [31:0] idat;
    logic [3:0]  itag;

    logic        ordy0, obusy0, owrite0, owfull0, oerr0;
    logic [7:0]  owaddr0;
    logic [31:0] owdat0;
    logic [3:0]  owtag0;
    logic        ordy1, obusy1, owrite1, owfull1, oerr1;
    logic [7:0]  owaddr1;
    logic [31:0] owdat1;
    logic [3:0]  owtag1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    wr_t   wq0[$], wq1[$];
    full_t fq0[$], fq1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (owrite0) wq0.push_back('{cyc, int'(owaddr0), owdat0});
        if (owrite1) wq1.push_back('{cyc, int'(owaddr1), owdat1});
        if (owfull0) fq0.push_back('{cyc, owtag0, oerr0});
        if (owfull1) fq1.push_back('{cyc, owtag1, oerr1});
    end

    ldpc_3gpp_dec_source_fix #(.pDO_PUNCT(0)) dut0 (
        .iclk(clk), .ireset(rst), .iclkena(clkena), .isop(isop), .ival(ival), .ieop(ieop),
        .idat(idat), .itag(itag), .ifulla(ifulla), .iemptya(iemptya), .ordy(ordy0),
        .obusy(obusy0), .owrite(owrite0), .owfull(owfull0), .owaddr(owaddr0),
        .owdat(owdat0), .owtag(owtag0), .oerr(oerr0)
    );

    ldpc_3gpp_dec_source_fix #(.pDO_PUNCT(1)) dut1 (
        .iclk(clk), .ireset(rst), .iclkena(clkena), .isop(isop), .ival(ival), .ieop(ieop),
        .idat(idat), .itag(itag), .ifulla(ifulla), .iemptya(iemptya), .ordy(ordy1),
        .obusy(obusy1), .owrite(owrite1), .owfull(owfull1), .owaddr(owaddr1),
        .owdat(owdat1), .owtag(owtag1), .oerr(oerr1)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected writes: each sop segment lands at cp, cp+1, ... (dropped past NUM),
    // then cp zero words at 0..cp-1; strobe after the last write.
    task automatic model(input logic [31:0] d[$], input int rs, input int s, input int cp,
                         output wr_t ex[$], output int err, output int fcyc);
        int base;
        int n;
        base = 0;
        n = d.size();
        ex.delete();
        for (int i = 0; i < n; i++) begin
            if (i == rs) base = i;
            if (cp + i - base < NUM) ex.push_back('{s + i, cp + i - base, d[i]});
        end
        for (int j = 0; j < cp; j++) ex.push_back('{s + n + j, j, 32'h0});
        err  = ((n - base) != (NUM - cp)) ? 1 : 0;
        fcyc = s + n + cp;
    endtask

    task automatic cmp_dut(input string nm, input wr_t got[$], input wr_t ex[$],
                           input full_t f[$], input int err, input int fcyc,
                           input logic [3:0] tag);
        int nbad;
        nbad = 0;
        chk({nm, "_wcount"}, got.size(), ex.size());
        for (int i = 0; i < got.size() && i < ex.size(); i++) begin
            if (got[i].cyc != ex[i].cyc || got[i].addr != ex[i].addr ||
                got[i].dat != ex[i].dat) begin
                if (nbad == 0)
                    $display("FAIL %s_write[%0d]: got c=%0d a=%0d d=%h, expected c=%0d a=%0d d=%h",
                             nm, i, got[i].cyc, got[i].addr, got[i].dat,
                             ex[i].cyc, ex[i].addr, ex[i].dat);
                nbad++;
            end
        end
        chk({nm, "_wmismatches"}, nbad, 0);
        chk({nm, "_full_count"}, f.size(), 1);
        if (f.size() > 0) begin
            chk({nm, "_full_cyc"}, f[0].cyc, fcyc);
            chk({nm, "_tag"}, int'(f[0].tag), int'(tag));
            chk({nm, "_err"}, int'(f[0].err), err);
        end
    endtask

    // e0/e1 < 0 means: take the length-error expectation from the model.
    task automatic run_frame(input int n, input int rs, input int e0, input int e1);
        logic [31:0] d[$];
        logic [3:0]  t1, t2, tl;
        int          s, m0, m1, f0, f1;
        wr_t         ex0[$], ex1[$];
        t1 = 4'($urandom);
        t2 = 4'($urandom);
        tl = (rs >= 0) ? t2 : t1;
        for (int i = 0; i < n; i++) d.push_back($urandom);
        wq0.delete(); wq1.delete(); fq0.delete(); fq1.delete();
        s = cyc + 1;
        for (int i = 0; i < n; i++) begin
            ival = 1'b1;
            isop = (i == 0) || (i == rs);
            ieop = (i == n - 1);
            idat = d[i];
            itag = (rs >= 0 && i >= rs) ? t2 : t1;
            if (i == 1) chk("ordy_drop_after_sop", int'(ordy0), 0);
            @(negedge clk);
        end
        ival = 1'b0; isop = 1'b0; ieop = 1'b0; idat = '0; itag = '0;
        for (int k = 0; k < 40 && (fq0.size() == 0 || fq1.size() == 0); k++) @(negedge clk);
        repeat (4) @(negedge clk);
        model(d, rs, s, 0, ex0, m0, f0);
        model(d, rs, s, P1, ex1, m1, f1);
        cmp_dut($sformatf("np_n%0d", n), wq0, ex0, fq0, (e0 < 0) ? m0 : e0, f0, tl);
        cmp_dut($sformatf("p_n%0d", n), wq1, ex1, fq1, (e1 < 0) ? m1 : e1, f1, tl);
        chk("ordy_after_frame", int'(ordy0), 1);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{52, -1, 0, 1};
        vecs[1] = '{48, -1, 1, 0};
        vecs[2] = '{30, -1, 1, 1};
        vecs[3] = '{1,  -1, 1, 1};
        vecs[4] = '{60, -1, 1, 1};
        vecs[5] = '{58, 10, 1, 0};
        vecs[6] = '{62, 10, 0, 1};
        vecs[7] = '{2,   1, 1, 1};

        rst = 1'b1; clkena = 1'b1; isop = 1'b0; ival = 1'b0; ieop = 1'b0;
        idat = '0; itag = '0; ifulla = 1'b0; iemptya = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_ordy", int'(ordy0), 0);
        chk("rst_owrite", int'(owrite0), 0);
        chk("rst_owfull", int'(owfull0), 0);
        chk("rst_owaddr", int'(owaddr0), 0);
        chk("rst_owdat", int'(owdat0 != 0), 0);
        chk("rst_owtag", int'(owtag0), 0);
        chk("rst_oerr", int'(oerr0), 0);
        chk("rst_obusy_empty", int'(obusy0), 0);
        chk("rst_p_owfull", int'(owfull1), 0);
        iemptya = 1'b0;
        #1;
        chk("rst_obusy_notempty", int'(obusy0), 1);
        iemptya = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("ordy_after_reset", int'(ordy0), 1);

        // Buffer full while idle holds off ordy.
        ifulla = 1'b1; iemptya = 1'b0;
        repeat (2) @(negedge clk);
        chk("full_ordy", int'(ordy0), 0);
        chk("full_obusy", int'(obusy0), 1);
        ifulla = 1'b0; iemptya = 1'b1;
        @(negedge clk);
        chk("full_release_ordy", int'(ordy0), 1);
        run_frame(52, -1, 0, 1);

        // Clock enable low freezes all state.
        clkena = 1'b0; ifulla = 1'b1;
        repeat (2) @(negedge clk);
        chk("clkena_hold_ordy", int'(ordy0), 1);
        clkena = 1'b1;
        @(negedge clk);
        chk("clkena_resume_ordy", int'(ordy0), 0);
        ifulla = 1'b0;
        @(negedge clk);

        // Reset in the middle of a frame aborts it with no strobe.
        for (int i = 0; i < 10; i++) begin
            ival = 1'b1; isop = (i == 0); ieop = 1'b0; idat = $urandom; itag = 4'h5;
            @(negedge clk);
        end
        ival = 1'b0; isop = 1'b0; rst = 1'b1;
        fq0.delete(); fq1.delete();
        @(negedge clk);
        chk("midrst_owrite", int'(owrite0), 0);
        chk("midrst_owaddr", int'(owaddr0), 0);
        chk("midrst_owdat", int'(owdat0 != 0), 0);
        chk("midrst_ordy", int'(ordy0), 0);
        chk("midrst_p_owrite", int'(owrite1), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_no_full", fq0.size() + fq1.size(), 0);

        for (int v = 0; v < 8; v++) run_frame(vecs[v].n, vecs[v].rs, vecs[v].e0, vecs[v].e1);

        for (int r = 0; r < 6; r++) begin
            int n;
            int rs;
            n  = $urandom_range(1, 64);
            rs = (n > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
            run_frame(n, rs, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
